// File: rtl/leg_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control path.
// Holds the FSM state encodings, the instruction class enum, opcode match
// constants/masks and the ALUOp codes handed to alu_control.
package leg_ctrl_pkg;

    // FSM states; codes 5 and 6 are unused and treated as faults
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CL_NONE    = 3'd0,
        CL_R       = 3'd1,
        CL_LDUR    = 3'd2,
        CL_STUR    = 3'd3,
        CL_CBZ     = 3'd4,
        CL_B       = 3'd5,
        CL_ILLEGAL = 3'd6
    } opclass_e;

    // Opcode field is IR[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // CBZ and B carry immediate bits inside the 11-bit field
    localparam logic [10:0] MSK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] MSK_B   = 11'b11111100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Wide enough for TIMEOUT up to 255
    localparam int WAIT_W = 8;

endpackage

// File: rtl/leg_opclass.sv
// Combinational opcode classifier.
// Ports:
//   opcode  in  11  IR[31:21]
//   opclass out 3   instruction class (opclass_e)
module leg_opclass
    import leg_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output opclass_e    opclass
);

    always_comb begin
        opclass = CL_ILLEGAL;
        if (opcode == OP_ADD || opcode == OP_SUB ||
            opcode == OP_AND || opcode == OP_ORR)
            opclass = CL_R;
        else if (opcode == OP_LDUR)
            opclass = CL_LDUR;
        else if (opcode == OP_STUR)
            opclass = CL_STUR;
        else if ((opcode & MSK_CBZ) == OP_CBZ)
            opclass = CL_CBZ;
        else if ((opcode & MSK_B) == OP_B)
            opclass = CL_B;
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the LEGv8 datapath.
// Issues per-state control strobes, waits on imem/dmem ready handshakes with
// a timeout, counts retired instructions and traps into a sticky FAULT state.
// Ports:
//   clk, reset            clock / synchronous active-high reset
//   opcode, zero          IR[31:21] and ALU zero flag
//   imem_ready/dmem_ready memory handshakes
//   imem_req .. mem_write datapath control strobes
//   retired               retired-instruction count (wraps)
//   fault                 sticky trap indicator
//   state                 current FSM state (debug)
module multicycle_sequencer
    import leg_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic [CNT_W-1:0] retired,
    output logic             fault,
    output logic [2:0]       state
);

    // Count value at which a still-missing ready becomes a fault
    localparam logic [WAIT_W-1:0] LP_TO_LAST = WAIT_W'(TIMEOUT - 1);

    state_e              r_state, w_next;
    opclass_e            r_class, w_dec_class;
    logic [WAIT_W-1:0]   r_wait;
    logic [CNT_W-1:0]    r_retired;
    logic                w_timeout;

    leg_opclass u_opclass (
        .opcode  (opcode),
        .opclass (w_dec_class)
    );

    assign w_timeout = (r_wait == LP_TO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next;
    end

    // Next-state logic; a ready in the timeout cycle takes precedence
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready)     w_next = ST_DECODE;
                else if (w_timeout) w_next = ST_FAULT;
            end
            ST_DECODE: begin
                case (w_dec_class)
                    CL_R, CL_LDUR, CL_STUR, CL_CBZ: w_next = ST_EXEC;
                    CL_B:                           w_next = ST_FETCH;
                    default:                        w_next = ST_FAULT;
                endcase
            end
            ST_EXEC: begin
                case (r_class)
                    CL_R:             w_next = ST_WB;
                    CL_LDUR, CL_STUR: w_next = ST_MEM;
                    CL_CBZ:           w_next = ST_FETCH;
                    default:          w_next = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (r_class == CL_LDUR)      w_next = ST_WB;
                    else if (r_class == CL_STUR) w_next = ST_FETCH;
                    else                         w_next = ST_FAULT;
                end else if (w_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_WB:    w_next = ST_FETCH;
            default:  w_next = ST_FAULT;
        endcase
    end

    // Output decode. ALU controls from EXEC are repeated in MEM/WB because
    // the datapath has no ALU result register.
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALUOP_ADD;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        fault      = 1'b0;
        if (!reset) begin
            if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
                case (r_class)
                    CL_R:    alu_op = ALUOP_FUNCT;
                    CL_LDUR, CL_STUR: begin
                        reg2loc = 1'b1;
                        alu_src = 1'b1;
                    end
                    CL_CBZ: begin
                        reg2loc = 1'b1;
                        alu_op  = ALUOP_PASSB;
                    end
                    default: ;
                endcase
            end
            case (r_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                ST_DECODE: begin
                    if (w_dec_class == CL_B) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (r_class == CL_CBZ) begin
                        pc_write = 1'b1;
                        pc_src   = zero;
                    end
                end
                ST_MEM: begin
                    mem_read  = (r_class == CL_LDUR);
                    mem_write = (r_class == CL_STUR);
                    pc_write  = (r_class == CL_STUR) && dmem_ready;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (r_class == CL_LDUR);
                    pc_write   = 1'b1;
                end
                ST_FAULT: fault = 1'b1;
                default:  ;
            endcase
        end
    end

    // Class latch, wait counter, retire counter. pc_write fires exactly once
    // per instruction, so it doubles as the retire event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_class   <= CL_NONE;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            if (r_state == ST_DECODE) r_class <= w_dec_class;
            if (pc_write) r_retired <= r_retired + CNT_W'(1);
            if (w_next != r_state)
                r_wait <= '0;
            else if ((r_state == ST_FETCH && !imem_ready) ||
                     (r_state == ST_MEM && !dmem_ready))
                r_wait <= r_wait + WAIT_W'(1);
        end
    end

    assign retired = r_retired;
    assign state   = r_state;

endmodule
